// File: rtl/entropy_src_adaptp_multi_ht.sv
// Multi-lane adaptive proportion health test with its own window counter,
// ones/first-sample-match counting, snapshots, watermarks and failure alert.
module entropy_src_adaptp_multi_ht #(
    parameter int unsigned RegWidth     = 16,
    parameter int unsigned NumLanes     = 8,
    parameter int unsigned FailCntWidth = 4,
    localparam int unsigned SelW        = $clog2(NumLanes)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumLanes-1:0]     entropy_bit_i,
    input  logic                    entropy_bit_vld_i,
    input  logic                    active_i,
    input  logic                    clear_i,
    input  logic                    mode_i,
    input  logic [1:0]              scope_i,
    input  logic [SelW-1:0]         lane_sel_i,
    input  logic [RegWidth-1:0]     window_size_i,
    input  logic [RegWidth-1:0]     thresh_hi_i,
    input  logic [RegWidth-1:0]     thresh_lo_i,
    input  logic [FailCntWidth-1:0] alert_thresh_i,
    output logic [RegWidth-1:0]     test_cnt_hi_o,
    output logic [RegWidth-1:0]     test_cnt_lo_o,
    output logic                    window_wrap_pulse_o,
    output logic                    test_fail_hi_pulse_o,
    output logic                    test_fail_lo_pulse_o,
    output logic [RegWidth-1:0]     hi_watermark_o,
    output logic [RegWidth-1:0]     lo_watermark_o,
    output logic [FailCntWidth-1:0] fail_cnt_o,
    output logic                    alert_o
);

    localparam int unsigned SumW = RegWidth + SelW + 1;

    logic [RegWidth-1:0]               wcnt_q, wcnt_d;
    logic [RegWidth-1:0]               wsize_q, wsize_d;
    logic [NumLanes-1:0][RegWidth-1:0] lane_q, lane_d;
    logic [NumLanes-1:0][RegWidth-1:0] lane_nxt;
    logic [NumLanes-1:0][RegWidth-1:0] snap_q, snap_d;
    logic [NumLanes-1:0]               ref_q, ref_d;
    logic                              wrap_q, wrap_d;
    logic [RegWidth-1:0]               hiwm_q, hiwm_d;
    logic [RegWidth-1:0]               lowm_q, lowm_d;
    logic [FailCntWidth-1:0]           fail_q, fail_d;
    logic                              alert_q, alert_d;

    logic [RegWidth-1:0] win_eff;
    logic [RegWidth-1:0] win_cur;
    logic [RegWidth:0]   cnt_inc;
    logic                accept;
    logic                first_s;
    logic                final_s;
    logic                wrap;
    logic                fail_hi;
    logic                fail_lo;
    logic [RegWidth-1:0] stat_hi;
    logic [RegWidth-1:0] stat_lo;
    logic [RegWidth-1:0] mx;
    logic [RegWidth-1:0] mn;
    logic [SumW-1:0]     sum;
    logic [RegWidth-1:0] sum_sat;
    logic [SelW:0]       sel_ext;
    logic [SelW-1:0]     sel;

    // Window size is latched on the first sample; a shrink below the
    // current count still closes the window on the next sample.
    always_comb begin
        win_eff = (window_size_i < RegWidth'(2)) ? RegWidth'(2) : window_size_i;
        accept  = entropy_bit_vld_i & active_i;
        first_s = (wcnt_q == '0);
        win_cur = first_s ? win_eff : wsize_q;
        cnt_inc = {1'b0, wcnt_q} + {{RegWidth{1'b0}}, 1'b1};
        final_s = accept & ((cnt_inc >= {1'b0, win_cur}) | (win_eff <= wcnt_q));
    end

    always_comb begin
        ref_d = ref_q;
        for (int k = 0; k < NumLanes; k++) begin
            lane_nxt[k] = lane_q[k];
            if (mode_i && first_s) begin
                lane_nxt[k] = RegWidth'(1);
                ref_d[k]    = entropy_bit_i[k];
            end else if (mode_i) begin
                lane_nxt[k] = lane_q[k]
                            + RegWidth'(entropy_bit_i[k] == ref_q[k]);
            end else begin
                lane_nxt[k] = lane_q[k] + RegWidth'(entropy_bit_i[k]);
            end
        end
        if (!accept) ref_d = ref_q;
    end

    always_comb begin
        wcnt_d  = wcnt_q;
        wsize_d = wsize_q;
        lane_d  = lane_q;
        snap_d  = snap_q;
        wrap_d  = 1'b0;
        if (!active_i) begin
            wcnt_d = '0;
            lane_d = '0;
        end else if (final_s) begin
            wcnt_d = '0;
            lane_d = '0;
            snap_d = lane_nxt;
            wrap_d = 1'b1;
        end else if (accept) begin
            wcnt_d  = cnt_inc[RegWidth-1:0];
            wsize_d = win_cur;
            lane_d  = lane_nxt;
        end
    end

    always_comb begin
        mx  = snap_q[0];
        mn  = snap_q[0];
        sum = '0;
        for (int k = 0; k < NumLanes; k++) begin
            if (snap_q[k] > mx) mx = snap_q[k];
            if (snap_q[k] < mn) mn = snap_q[k];
            sum = sum + SumW'(snap_q[k]);
        end
        sum_sat = (sum[SumW-1:RegWidth] != '0) ? {RegWidth{1'b1}}
                                                : sum[RegWidth-1:0];
        sel_ext = {1'b0, lane_sel_i};
        sel     = (sel_ext < (SelW+1)'(NumLanes)) ? lane_sel_i : '0;
        case (scope_i)
            2'd0: begin
                stat_hi = mx;
                stat_lo = mn;
            end
            2'd1: begin
                stat_hi = sum_sat;
                stat_lo = sum_sat;
            end
            default: begin
                stat_hi = snap_q[sel];
                stat_lo = snap_q[sel];
            end
        endcase
    end

    // Pulses are suppressed while inactive or clearing.
    always_comb begin
        wrap    = wrap_q & active_i & ~clear_i;
        fail_hi = wrap & (stat_hi > thresh_hi_i);
        fail_lo = wrap & (stat_lo < thresh_lo_i);
        hiwm_d  = hiwm_q;
        lowm_d  = lowm_q;
        fail_d  = fail_q;
        alert_d = alert_q;
        if (wrap) begin
            if (stat_hi > hiwm_q) hiwm_d = stat_hi;
            if (stat_lo < lowm_q) lowm_d = stat_lo;
            if (fail_hi | fail_lo) begin
                fail_d = (fail_q == '1) ? fail_q
                                        : fail_q + FailCntWidth'(1);
            end else begin
                fail_d = '0;
            end
            if ((alert_thresh_i != '0) && (fail_d >= alert_thresh_i)) begin
                alert_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wcnt_q  <= '0;
            wsize_q <= '0;
            lane_q  <= '0;
            snap_q  <= '0;
            ref_q   <= '0;
            wrap_q  <= 1'b0;
            hiwm_q  <= '0;
            lowm_q  <= '1;
            fail_q  <= '0;
            alert_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            wsize_q <= wsize_d;
            lane_q  <= lane_d;
            snap_q  <= snap_d;
            ref_q   <= ref_d;
            wrap_q  <= wrap_d;
            hiwm_q  <= hiwm_d;
            lowm_q  <= lowm_d;
            fail_q  <= fail_d;
            alert_q <= alert_d;
        end
    end

    assign test_cnt_hi_o        = stat_hi;
    assign test_cnt_lo_o        = stat_lo;
    assign window_wrap_pulse_o  = wrap;
    assign test_fail_hi_pulse_o = fail_hi;
    assign test_fail_lo_pulse_o = fail_lo;
    assign hi_watermark_o       = hiwm_q;
    assign lo_watermark_o       = lowm_q;
    assign fail_cnt_o           = fail_q;
    assign alert_o              = alert_q;

endmodule

// File: tb/tb_entropy_src_adaptp_multi_ht.sv
// Directed bench for entropy_src_adaptp_multi_ht (4 lanes, 4-bit registers).
module tb_entropy_src_adaptp_multi_ht;

    localparam int RW = 4;
    localparam int NL = 4;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] bits;
    logic          vld;
    logic          active;
    logic          clear;
    logic          mode;
    logic [1:0]    scope;
    logic [1:0]    lane_sel;
    logic [RW-1:0] wsize;
    logic [RW-1:0] th_hi;
    logic [RW-1:0] th_lo;
    logic [FW-1:0] al_th;
    logic [RW-1:0] cnt_hi;
    logic [RW-1:0] cnt_lo;
    logic          wrap;
    logic          f_hi;
    logic          f_lo;
    logic [RW-1:0] hi_wm;
    logic [RW-1:0] lo_wm;
    logic [FW-1:0] fcnt;
    logic          alert;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    entropy_src_adaptp_multi_ht #(
        .RegWidth(RW),
        .NumLanes(NL),
        .FailCntWidth(FW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .entropy_bit_i(bits),
        .entropy_bit_vld_i(vld),
        .active_i(active),
        .clear_i(clear),
        .mode_i(mode),
        .scope_i(scope),
        .lane_sel_i(lane_sel),
        .window_size_i(wsize),
        .thresh_hi_i(th_hi),
        .thresh_lo_i(th_lo),
        .alert_thresh_i(al_th),
        .test_cnt_hi_o(cnt_hi),
        .test_cnt_lo_o(cnt_lo),
        .window_wrap_pulse_o(wrap),
        .test_fail_hi_pulse_o(f_hi),
        .test_fail_lo_pulse_o(f_lo),
        .hi_watermark_o(hi_wm),
        .lo_watermark_o(lo_wm),
        .fail_cnt_o(fcnt),
        .alert_o(alert)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bits = '0; vld = 1'b0; active = 1'b0; clear = 1'b0;
        mode = 1'b0; scope = 2'd0; lane_sel = 2'd0; wsize = 4'd8;
        th_hi = 4'd6; th_lo = 4'd2; al_th = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_hi", cnt_hi, 0);
        chk("rst_lo", cnt_lo, 0);
        chk("rst_lowm", lo_wm, 4'hF);
        chk("rst_hiwm", hi_wm, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_alert", alert, 0);

        // ones mode, lanes 1,0,1,0
        active = 1'b1; vld = 1'b1; bits = 4'b0101;
        repeat (7) tick();
        chk("t1_nowrap7", wrap, 0);
        tick();
        chk("t1_wrap", wrap, 1);
        chk("t1_hi", cnt_hi, 8);
        chk("t1_lo", cnt_lo, 0);
        chk("t1_fhi", f_hi, 1);
        chk("t1_flo", f_lo, 1);
        vld = 1'b0;
        tick();
        chk("t1_wrap_once", wrap, 0);
        chk("t1_hiwm", hi_wm, 8);
        chk("t1_lowm", lo_wm, 0);
        chk("t1_fcnt", fcnt, 1);
        chk("t1_alert_dis", alert, 0);

        // match mode, W=4
        do_clear();
        chk("t2_clr_lowm", lo_wm, 4'hF);
        chk("t2_clr_fcnt", fcnt, 0);
        mode = 1'b1; wsize = 4'd4; scope = 2'd2; lane_sel = 2'd0;
        vld = 1'b1;
        bits = 4'b0110; tick();
        bits = 4'b1010; tick();
        bits = 4'b1111; tick();
        bits = 4'b1010; tick();
        chk("t2_wrap", wrap, 1);
        chk("t2_hi", cnt_hi, 3);
        chk("t2_lo", cnt_lo, 3);
        chk("t2_fhi", f_hi, 0);
        chk("t2_flo", f_lo, 0);
        vld = 1'b0;
        tick();
        chk("t2_hiwm", hi_wm, 3);
        chk("t2_lowm", lo_wm, 3);
        scope = 2'd0; #1;
        chk("t2_s0_hi", cnt_hi, 4);
        chk("t2_s0_lo", cnt_lo, 1);
        scope = 2'd1; #1;
        chk("t2_s1_sum", cnt_hi, 10);
        scope = 2'd3; lane_sel = 2'd1; #1;
        chk("t2_s3_l1", cnt_lo, 4);
        chk("t2_nopulse", f_lo, 0);

        // saturating sum, W=15
        do_clear();
        mode = 1'b0; scope = 2'd1; wsize = 4'd15; bits = 4'hF; vld = 1'b1;
        repeat (15) tick();
        chk("t3_wrap", wrap, 1);
        chk("t3_sum_sat", cnt_hi, 15);
        chk("t3_fhi", f_hi, 1);
        chk("t3_flo", f_lo, 0);
        vld = 1'b0;
        tick();
        chk("t3_hiwm", hi_wm, 15);
        chk("t3_lowm", lo_wm, 15);

        // consecutive failures and alert
        do_clear();
        scope = 2'd0; wsize = 4'd4; al_th = 4'd3; bits = 4'b0101;
        for (int w = 1; w <= 3; w++) begin
            vld = 1'b1;
            repeat (4) tick();
            chk("t4_flo", f_lo, 1);
            vld = 1'b0;
            tick();
            chk("t4_fcnt", fcnt, w);
            chk("t4_alert", alert, (w >= 3) ? 1 : 0);
        end
        bits = 4'hF; vld = 1'b1;
        repeat (4) tick();
        chk("t4_pass_flo", f_lo, 0);
        chk("t4_pass_fhi", f_hi, 0);
        vld = 1'b0;
        tick();
        chk("t4_pass_fcnt", fcnt, 0);
        chk("t4_alert_sticky", alert, 1);
        do_clear();
        chk("t4_clr_alert", alert, 0);
        chk("t4_clr_lowm", lo_wm, 4'hF);

        // clear on the final sample, then active drop mid-window
        al_th = '0; wsize = 4'd8; bits = 4'hF; vld = 1'b1;
        repeat (7) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0; vld = 1'b0;
        chk("t5_clr_nowrap", wrap, 0);
        chk("t5_clr_hi", cnt_hi, 0);
        tick();
        chk("t5_clr_nowrap2", wrap, 0);
        vld = 1'b1;
        repeat (4) tick();
        active = 1'b0;
        tick();
        chk("t5_inact_nowrap", wrap, 0);
        active = 1'b1;
        repeat (7) tick();
        chk("t5_nowrap7", wrap, 0);
        tick();
        chk("t5_wrap8", wrap, 1);
        chk("t5_hi8", cnt_hi, 8);
        vld = 1'b0;
        tick();

        // minimum window of 2, gaps do not advance
        wsize = 4'd0; bits = 4'b0011;
        vld = 1'b1; tick();
        vld = 1'b0; tick(); tick();
        chk("t6_gap_nowrap", wrap, 0);
        vld = 1'b1; tick();
        chk("t6_w0_wrap", wrap, 1);
        chk("t6_w0_hi", cnt_hi, 2);
        vld = 1'b0; tick();
        wsize = 4'd1;
        vld = 1'b1; tick();
        chk("t6_w1_nowrap", wrap, 0);
        tick();
        chk("t6_w1_wrap", wrap, 1);
        chk("t6_w1_lo", cnt_lo, 0);
        vld = 1'b0; tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/entropy_src_adaptp_multi_ht.md
Name: entropy_src_adaptp_multi_ht

Overview:
Next-generation adaptive proportion health test for entropy_src. It supports N parallel RNG lanes and owns its own window counter instead of taking an external wrap pulse. It offers two counting modes: ones-count, and NIST first-sample match. It also adds per-window snapshots, lifetime watermarks and a consecutive-failure alert. It sits beside the other health tests, fed by the raw RNG sample path, and reports to the entropy_src main FSM and CSRs.

Parameters:
RegWidth, 16, width of counters, thresholds, window size and outputs
NumLanes, 8, number of RNG bit lanes (>=2)
FailCntWidth, 4, width of the consecutive-failure counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
entropy_bit_i  in  NumLanes  one RNG bit per lane
entropy_bit_vld_i  in  1  sample valid
active_i  in  1  test enabled
clear_i  in  1  synchronous clear of all state
mode_i  in  1  0 = count ones; 1 = count matches to the window's first sample (per lane)
scope_i  in  2  0 = per-lane max/min; 1 = sum of lanes; 2/3 = single lane
lane_sel_i  in  $clog2(NumLanes)  lane used when scope_i>=2
window_size_i  in  RegWidth  samples per window
thresh_hi_i  in  RegWidth  high threshold
thresh_lo_i  in  RegWidth  low threshold
alert_thresh_i  in  FailCntWidth  consecutive failing windows that trigger an alert; 0 = disabled
test_cnt_hi_o  out  RegWidth  last window high statistic
test_cnt_lo_o  out  RegWidth  last window low statistic
window_wrap_pulse_o  out  1  window completed
test_fail_hi_pulse_o  out  1  high-threshold failure
test_fail_lo_pulse_o  out  1  low-threshold failure
hi_watermark_o  out  RegWidth  max test_cnt_hi_o since clear
lo_watermark_o  out  RegWidth  min test_cnt_lo_o since clear
fail_cnt_o  out  FailCntWidth  consecutive failing windows
alert_o  out  1  sticky alert

Behaviour:
- Reset/clear values: all live counters, snapshots, outputs, pulses, fail_cnt_o and alert_o are 0; lo_watermark_o is all-ones.
- clear_i has the same effect as reset and wins over every simultaneous event; no pulses are produced in a clear cycle or the cycle after it.
- Inactive (active_i=0):
  - Live lane counters and the window counter are held at 0; no pulses.
  - Snapshots, watermarks, fail_cnt_o and alert_o hold.
  - Deasserting active_i mid-window discards the partial window.
- Window size: effective size W = max(window_size_i, 2). The window counter counts accepted samples (valid && active).
- Ones mode: each lane counter adds entropy_bit_i[k] on every accepted sample.
- Match mode:
  - On the first sample of a window, the lane bit is captured as that lane's reference and the lane counter is set to 1.
  - Each later sample adds 1 when the bit equals the reference.
- Final sample (accepted sample number W):
  - Lane counts including this sample are loaded into the snapshot registers.
  - Live counters and the window counter restart at 0, so the next sample starts a fresh window with no gap.
- Evaluation, one cycle after the final sample:
  - window_wrap_pulse_o=1 for exactly one cycle.
  - Fail pulses are evaluated in that same cycle from the new snapshot.
- Statistics from the snapshot:
  - scope 0: hi = max lane count, lo = min lane count.
  - scope 1: hi = lo = sum of lane counts, saturating at 2^RegWidth-1.
  - scope 2/3: hi = lo = the selected lane's count; lane_sel_i>=NumLanes selects lane 0.
  - test_cnt_hi_o/lo_o are combinational from the snapshot and scope, and stable between windows.
- Fail pulses: test_fail_hi_pulse_o = wrap && hi > thresh_hi_i; test_fail_lo_pulse_o = wrap && lo < thresh_lo_i. Comparisons are unsigned.
- Watermarks, updated in the wrap cycle (visible next cycle): hi_watermark = max(hi_watermark, hi); lo_watermark = min(lo_watermark, lo).
- Failure counter and alert, at wrap:
  - Either fail set: fail_cnt_o increments, saturating at all-ones.
  - Neither fail set: fail_cnt_o returns to 0.
  - alert_o sets when alert_thresh_i!=0 && the updated fail_cnt >= alert_thresh_i. It is cleared only by reset/clear_i.
- Counter range: no lane counter can exceed W-1+1 <= 2^RegWidth-1, so lane counters never overflow.
- Config changes: window_size_i changes take effect at the next window boundary. A mid-window shrink below the current sample count ends the window on the next accepted sample.

Test Plan:
1. NumLanes=4, ones mode, W=8, lanes fed constant 1,0,1,0 → wrap one cycle after the 8th valid; scope0 hi=8, lo=0; thresh_hi=6 gives hi pulse, thresh_lo=2 gives lo pulse; both pulses coincide with wrap.
2. Match mode, W=4, lane0 sequence 0,0,1,0 → lane0 count 3; lane pattern 1,1,1,1 → count 4. Scope2 with lane_sel=0 gives hi=lo=3.
3. Scope1 with RegWidth=4, NumLanes=4, W=15, all ones → sum saturates at 15 (not 60); hi_watermark_o=15 the following cycle.
4. alert_thresh=3, three consecutive failing windows → fail_cnt 1,2,3 and alert_o=1 after the third wrap. A passing window then resets fail_cnt to 0 while alert_o stays 1. clear_i drops alert_o to 0 and lo_watermark_o to all-ones.
5. clear_i asserted on the final-sample cycle → no wrap pulse, counters 0. active_i dropped at sample 5 of 8, then restored → 8 more samples are needed before the next wrap.
6. window_size_i=0 and 1 → wrap every 2 valid samples; entropy_bit_vld_i gaps do not advance the window.
